bk_mem_arbiter: RTL and testbench

Parametrised multi-channel arbiter and access sequencer for the shared asynchronous 16-bit SRAM. It replaces the fixed single-requestor RAM exchange cycle.
- Serves NCH requestors: CPU, video fetch, debug/JTAG port, and future DMA/disk.
- One channel (video) has absolute priority; all other channels share access round-robin.
- Wait states are set by a parameter.
- Sits between the core/peripheral requestors and the SRAM pins at top level.

---
 rtl/bk_mem_arbiter.sv | 118 +++++++++++
 tb/tb_bk_mem_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bk_mem_arbiter.sv
// bk_mem_arbiter: shared async SRAM arbiter, one absolute-priority channel plus round-robin for the rest.
module bk_mem_arbiter #(
    parameter int NCH     = 3,
    parameter int AW      = 18,
    parameter int DW      = 16,
    parameter int WAIT    = 3,
    parameter int PRIO_CH = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NCH-1:0]        req,
    input  logic [NCH-1:0]        we,
    input  logic [NCH*AW-1:0]     addr,
    input  logic [NCH*DW-1:0]     wdata,
    input  logic [NCH*DW/8-1:0]   be,
    output logic [NCH-1:0]        ack,
    output logic [DW-1:0]         rdata,
    output logic                  busy,
    output logic [2:0]            grant_id,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_wdata,
    output logic [DW/8-1:0]       mem_be_n,
    output logic                  mem_oe_n,
    output logic                  mem_we_n,
    input  logic [DW-1:0]         mem_rdata
);
    localparam int BW = DW / 8;
    localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, DONE = 2'd3;
    localparam logic [2:0] PTR_RST = 3'((PRIO_CH + 1) % NCH);
    localparam logic [2:0] PRIO_ID = 3'(PRIO_CH);
    localparam logic [2:0] LAST_ID = 3'(NCH - 1);
    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic          r_we;
    logic [2:0]    r_ptr;
    logic [2:0]    w_win;
    logic [3:0]    w_best;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    logic [BW-1:0] w_be;
    logic          w_we;
    // Round-robin pick = requesting non-priority channel at the smallest distance from r_ptr.
    always_comb begin
        w_win   = '0;
        w_best  = 4'(NCH);
        w_addr  = '0;
        w_wdata = '0;
        w_be    = '0;
        w_we    = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (req[c] && c != PRIO_CH && 4'((c + NCH - int'(r_ptr)) % NCH) < w_best) begin
                w_best  = 4'((c + NCH - int'(r_ptr)) % NCH);
                w_win   = 3'(c);
                w_addr  = addr[c*AW +: AW];
                w_wdata = wdata[c*DW +: DW];
                w_be    = be[c*BW +: BW];
                w_we    = we[c];
            end
        end
        if (req[PRIO_CH]) begin
            w_win   = PRIO_ID;
            w_addr  = addr[PRIO_CH*AW +: AW];
            w_wdata = wdata[PRIO_CH*DW +: DW];
            w_be    = be[PRIO_CH*BW +: BW];
            w_we    = we[PRIO_CH];
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_ptr     <= PTR_RST;
            ack       <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
            grant_id  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be_n  <= '1;
            mem_oe_n  <= 1'b1;
            mem_we_n  <= 1'b1;
        end else begin
            ack <= '0;
            case (r_state)
                IDLE: if (|req) begin
                    mem_addr  <= w_addr;
                    mem_wdata <= w_wdata;
                    mem_be_n  <= ~w_be;
                    r_we      <= w_we;
                    grant_id  <= w_win;
                    busy      <= 1'b1;
                    r_state   <= SETUP;
                end
                SETUP: begin
                    r_cnt    <= 4'(WAIT - 1);
                    mem_oe_n <= r_we;
                    mem_we_n <= ~r_we;
                    r_state  <= ACCESS;
                end
                ACCESS: if (r_cnt == 4'd0) begin
                    if (!r_we) rdata <= mem_rdata;
                    mem_oe_n <= 1'b1;
                    mem_we_n <= 1'b1;
                    ack      <= {{(NCH-1){1'b0}}, 1'b1} << grant_id;
                    r_state  <= DONE;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
                DONE: begin
                    if (grant_id != PRIO_ID) r_ptr <= (grant_id == LAST_ID) ? 3'd0 : grant_id + 3'd1;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bk_mem_arbiter.sv
// tb_bk_mem_arbiter: directed checks of the SRAM arbiter (default config plus NCH=2/WAIT=1/PRIO_CH=1).
module tb_bk_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  req = '0, we = '0;
    logic [53:0] addr = '0;
    logic [47:0] wdata = '0;
    logic [5:0]  be = '0;
    logic [2:0]  ack;
    logic [15:0] rdata, mwdata;
    logic [15:0] mrdata = '0;
    logic        busy, oe, wen;
    logic [2:0]  gid;
    logic [17:0] maddr;
    logic [1:0]  mben;
    logic [1:0]  b_req = '0, b_we = '0;
    logic [35:0] b_addr = '0;
    logic [31:0] b_wdata = '0;
    logic [3:0]  b_be = '0;
    logic [1:0]  b_ack;
    logic [15:0] b_rdata, b_mwdata;
    logic [15:0] b_mrdata = '0;
    logic        b_busy, b_oe, b_wen;
    logic [2:0]  b_gid;
    logic [17:0] b_maddr;
    logic [1:0]  b_mben;
    int n_chk = 0, n_fail = 0;
    int got[4], at[4], na, low;
    always #5 clk = ~clk;
    bk_mem_arbiter dut (
        .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .ack(ack), .rdata(rdata), .busy(busy), .grant_id(gid), .mem_addr(maddr), .mem_wdata(mwdata),
        .mem_be_n(mben), .mem_oe_n(oe), .mem_we_n(wen), .mem_rdata(mrdata)
    );
    bk_mem_arbiter #(.NCH(2), .AW(18), .DW(16), .WAIT(1), .PRIO_CH(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .req(b_req), .we(b_we), .addr(b_addr), .wdata(b_wdata), .be(b_be),
        .ack(b_ack), .rdata(b_rdata), .busy(b_busy), .grant_id(b_gid), .mem_addr(b_maddr), .mem_wdata(b_mwdata),
        .mem_be_n(b_mben), .mem_oe_n(b_oe), .mem_we_n(b_wen), .mem_rdata(b_mrdata)
    );
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    initial begin
        repeat (3) tick;
        chk("rst_ack", 32'(ack), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_gid", 32'(gid), 0);
        chk("rst_oe", 32'(oe), 1);
        chk("rst_we", 32'(wen), 1);
        chk("rst_be_n", 32'(mben), 3);
        chk("rst_addr", 32'(maddr), 0);
        chk("rst_wdata", 32'(mwdata), 0);
        reset_n = 1'b1;
        tick;
        // single read on ch1
        addr[18 +: 18] = 18'h01234;
        be[2 +: 2] = 2'b11;
        mrdata = 16'hBEEF;
        req = 3'b010;
        tick;
        chk("t1_gid", 32'(gid), 1);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_addr", 32'(maddr), 32'h01234);
        chk("t1_setup_oe", 32'(oe), 1);
        for (int c = 2; c <= 4; c++) begin
            tick;
            chk("t1_oe_low", 32'(oe), 0);
            chk("t1_we_high", 32'(wen), 1);
            chk("t1_no_ack", 32'(ack), 0);
        end
        tick;
        chk("t1_ack", 32'(ack), 32'b010);
        chk("t1_rdata", 32'(rdata), 32'hBEEF);
        chk("t1_done_oe", 32'(oe), 1);
        req = '0;
        tick;
        chk("t1_ack_pulse", 32'(ack), 0);
        chk("t1_idle", 32'(busy), 0);
        // single byte-lane write on ch2
        addr[36 +: 18] = 18'h3FFFF;
        wdata[32 +: 16] = 16'hA55A;
        be[4 +: 2] = 2'b01;
        we = 3'b100;
        mrdata = 16'h1111;
        req = 3'b100;
        tick;
        chk("t2_be_n", 32'(mben), 32'b10);
        chk("t2_addr", 32'(maddr), 32'h3FFFF);
        chk("t2_wdata", 32'(mwdata), 32'hA55A);
        chk("t2_setup_we", 32'(wen), 1);
        chk("t2_gid", 32'(gid), 2);
        low = 0;
        for (int c = 2; c <= 5; c++) begin
            tick;
            if (!wen) low++;
            chk("t2_addr_stable", 32'(maddr), 32'h3FFFF);
            chk("t2_oe_high", 32'(oe), 1);
        end
        chk("t2_we_cycles", 32'(low), 3);
        chk("t2_ack", 32'(ack), 32'b100);
        chk("t2_rdata_kept", 32'(rdata), 32'hBEEF);
        req = '0;
        we = '0;
        tick;
        // round-robin ch1/ch2 streaming
        req = 3'b110;
        na = 0;
        for (int t = 1; t <= 30 && na < 4; t++) begin
            tick;
            if (ack != 0) begin
                got[na] = ack[1] ? 1 : ack[2] ? 2 : ack[0] ? 0 : 9;
                at[na] = t;
                na++;
                if (na == 4) req = '0;
            end
        end
        chk("t3_ack_count", 32'(na), 4);
        chk("t3_g0", 32'(got[0]), 1);
        chk("t3_g1", 32'(got[1]), 2);
        chk("t3_g2", 32'(got[2]), 1);
        chk("t3_g3", 32'(got[3]), 2);
        chk("t3_at0", 32'(at[0]), 5);
        chk("t3_at1", 32'(at[1]), 11);
        chk("t3_at3", 32'(at[3]), 23);
        tick;
        chk("t3_idle", 32'(busy), 0);
        // priority channel cuts in while ch1 is in ACCESS
        req = 3'b110;
        na = 0;
        for (int t = 1; t <= 30 && na < 3; t++) begin
            tick;
            if (t == 2) req[0] = 1'b1;
            if (ack != 0) begin
                got[na] = ack[1] ? 1 : ack[2] ? 2 : ack[0] ? 0 : 9;
                at[na] = t;
                na++;
                if (ack[0]) req[0] = 1'b0;
                if (na == 3) req = '0;
            end
        end
        chk("t4_ack_count", 32'(na), 3);
        chk("t4_g0", 32'(got[0]), 1);
        chk("t4_g1", 32'(got[1]), 0);
        chk("t4_g2", 32'(got[2]), 2);
        chk("t4_at2", 32'(at[2]), 17);
        tick;
        // req dropped during SETUP still completes
        req = 3'b010;
        tick;
        chk("t5_gid", 32'(gid), 1);
        req = '0;
        for (int c = 2; c <= 4; c++) begin
            tick;
            chk("t5_no_early_ack", 32'(ack), 0);
        end
        tick;
        chk("t5_ack_after_drop", 32'(ack), 32'b010);
        tick;
        // reset asserted in the middle of a write
        we = 3'b100;
        req = 3'b100;
        tick;
        tick;
        chk("t6_we_low", 32'(wen), 0);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_we_async", 32'(wen), 1);
        chk("t6_oe_async", 32'(oe), 1);
        chk("t6_gid", 32'(gid), 0);
        chk("t6_busy", 32'(busy), 0);
        req = '0;
        we = '0;
        tick;
        tick;
        chk("t6_no_ack", 32'(ack), 0);
        reset_n = 1'b1;
        tick;
        req = 3'b110;
        tick;
        chk("t6_ptr_reset", 32'(gid), 1);
        req = '0;
        na = 0;
        for (int t = 0; t < 10 && ack == 0; t++) tick;
        chk("t6_ack", 32'(ack), 32'b010);
        tick;
        // NCH=2, WAIT=1, PRIO_CH=1 instance
        b_addr[0 +: 18] = 18'h00055;
        b_be = 4'b1111;
        b_mrdata = 16'h1234;
        b_req = 2'b01;
        tick;
        chk("b_setup_oe", 32'(b_oe), 1);
        chk("b_gid0", 32'(b_gid), 0);
        tick;
        chk("b_oe_low", 32'(b_oe), 0);
        chk("b_no_ack", 32'(b_ack), 0);
        tick;
        chk("b_ack", 32'(b_ack), 32'b01);
        chk("b_rdata", 32'(b_rdata), 32'h1234);
        chk("b_done_oe", 32'(b_oe), 1);
        b_req = '0;
        tick;
        b_req = 2'b11;
        tick;
        chk("b_prio_gid", 32'(b_gid), 1);
        b_req = '0;
        tick;
        tick;
        chk("b_prio_ack", 32'(b_ack), 32'b10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
